base_aqueue: RTL and testbench

Parametrised valid/ready elastic buffer. It is the multi-entry successor of the single-stage pipeline latch, built for long-haul AFU datapaths.
- Holds up to `depth` transfers.
- `i_r` depends only on registered occupancy, so there is no combinational `o_r`-to-`i_r` path.
- Adds an occupancy output, a synchronous flush, and optional zero-qualified output data.
- Sits between producer and consumer stages anywhere a one-deep latch would throttle throughput or close timing poorly.

---
 rtl/base_aqueue.sv | 56 +++++
 tb/tb_base_aqueue.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/base_aqueue.sv
// base_aqueue: multi-entry valid/ready elastic buffer with occupancy, flush and optional zero-qualified output
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   i_flush : synchronous flush, discards all entries and any same-cycle push/pop
//   i_v/i_d/i_r : producer valid / data / ready
//   o_v/o_d/o_r : consumer valid / data / ready
//   count   : registered occupancy, 0..depth
module base_aqueue #(
  parameter int width = 1,
  parameter int depth = 2,
  parameter bit dq = 0,
  parameter int cw = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_v,
  input  logic [0:width-1] i_d,
  output logic             i_r,
  output logic             o_v,
  output logic [0:width-1] o_d,
  input  logic             o_r,
  output logic [0:cw-1]    count
);
  localparam int aw = $clog2(depth);
  logic [0:width-1] mem [depth];
  logic [aw-1:0] wp, rp;
  logic [cw-1:0] cnt;
  logic push, pop;
  // ready looks only at registered occupancy and reset, never at o_r
  always_comb begin
    i_r = reset && (cnt != cw'(depth));
    o_v = cnt != '0;
    push = i_v & i_r;
    pop = o_v & o_r;
    o_d = dq ? (mem[rp] & {width{o_v}}) : mem[rp];
    count = cnt;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      wp <= '0;
      rp <= '0;
    end else if (i_flush) begin
      cnt <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= (wp == aw'(depth - 1)) ? '0 : wp + aw'(1);
      if (pop) rp <= (rp == aw'(depth - 1)) ? '0 : rp + aw'(1);
      cnt <= cnt + cw'(push) - cw'(pop);
    end
  // storage is deliberately not reset
  always_ff @(posedge clk)
    if (push && !i_flush) mem[wp] <= i_d;
endmodule

// File: tb/tb_base_aqueue.sv
// tb_base_aqueue: directed checks of base_aqueue at depth 4 and depth 3
module tb_base_aqueue;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_fl = 1'b0, a_v = 1'b0, a_r = 1'b0, a_ir, a_ov;
  logic [7:0] a_d = '0, a_od;
  logic [2:0] a_cnt;
  logic b_fl = 1'b0, b_v = 1'b0, b_r = 1'b0, b_ir, b_ov;
  logic [7:0] b_d = '0, b_od;
  logic [1:0] b_cnt;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  base_aqueue #(.width(8), .depth(4), .dq(1)) u_a (
    .clk(clk), .reset(reset), .i_flush(a_fl), .i_v(a_v), .i_d(a_d), .i_r(a_ir),
    .o_v(a_ov), .o_d(a_od), .o_r(a_r), .count(a_cnt));
  base_aqueue #(.width(8), .depth(3), .dq(1)) u_b (
    .clk(clk), .reset(reset), .i_flush(b_fl), .i_v(b_v), .i_d(b_d), .i_r(b_ir),
    .o_v(b_ov), .o_d(b_od), .o_r(b_r), .count(b_cnt));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_a(input logic [7:0] d);
    a_v = 1'b1;
    a_d = d;
    step();
    a_v = 1'b0;
  endtask
  initial begin
    int mcnt, sent, recv, cyc;
    logic pu, po;
    repeat (3) step();
    chk("rst_ov", a_ov, 0);
    chk("rst_ir", a_ir, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_od", a_od, 0);
    chk("rst_b_ir", b_ir, 0);
    reset = 1'b1;
    step();
    chk("rel_ir", a_ir, 1);
    chk("rel_od", a_od, 0);
    chk("rel_cnt", a_cnt, 0);
    chk("rel_ov", a_ov, 0);
    push_a(8'h11);
    chk("fill_cnt1", a_cnt, 1);
    chk("fill_ov", a_ov, 1);
    chk("fill_od", a_od, 8'h11);
    push_a(8'h22);
    chk("fill_cnt2", a_cnt, 2);
    push_a(8'h33);
    chk("fill_cnt3", a_cnt, 3);
    chk("fill_ir3", a_ir, 1);
    push_a(8'h44);
    chk("fill_cnt4", a_cnt, 4);
    chk("full_ir", a_ir, 0);
    push_a(8'h55);
    chk("full_nopush_cnt", a_cnt, 4);
    chk("full_head", a_od, 8'h11);
    a_r = 1'b1;
    step();
    chk("drain_cnt3", a_cnt, 3);
    chk("drain_od22", a_od, 8'h22);
    step();
    chk("drain_cnt2", a_cnt, 2);
    chk("drain_od33", a_od, 8'h33);
    step();
    chk("drain_cnt1", a_cnt, 1);
    chk("drain_od44", a_od, 8'h44);
    step();
    chk("drain_cnt0", a_cnt, 0);
    chk("drain_ov0", a_ov, 0);
    chk("drain_od0", a_od, 0);
    a_r = 1'b0;
    push_a(8'h11);
    push_a(8'h22);
    push_a(8'h33);
    push_a(8'h44);
    chk("refill_cnt4", a_cnt, 4);
    a_v = 1'b1;
    a_d = 8'h55;
    a_r = 1'b1;
    step();
    chk("fp_pop_only_cnt", a_cnt, 3);
    chk("fp_ir_back", a_ir, 1);
    chk("fp_od22", a_od, 8'h22);
    step();
    a_v = 1'b0;
    chk("fp_both_cnt", a_cnt, 3);
    chk("fp_od33", a_od, 8'h33);
    step();
    chk("fp_od44", a_od, 8'h44);
    step();
    chk("fp_od55", a_od, 8'h55);
    chk("fp_cnt1", a_cnt, 1);
    step();
    chk("fp_empty", a_ov, 0);
    a_r = 1'b0;
    push_a(8'h01);
    push_a(8'h02);
    chk("fl_pre_cnt", a_cnt, 2);
    a_fl = 1'b1;
    a_v = 1'b1;
    a_d = 8'hAA;
    a_r = 1'b1;
    step();
    a_fl = 1'b0;
    a_r = 1'b0;
    chk("fl_cnt0", a_cnt, 0);
    chk("fl_ov0", a_ov, 0);
    chk("fl_od0", a_od, 0);
    push_a(8'hBB);
    chk("fl_cnt1", a_cnt, 1);
    chk("fl_next_bb", a_od, 8'hBB);
    a_r = 1'b1;
    step();
    a_r = 1'b0;
    chk("fl_drained", a_cnt, 0);
    mcnt = 0;
    sent = 0;
    recv = 0;
    cyc = 0;
    while (recv < 10 && cyc < 200) begin
      b_v = sent < 10;
      b_d = 8'(sent);
      b_r = 1'($urandom_range(0, 1));
      pu = b_v && mcnt != 3;
      po = b_r && mcnt != 0;
      chk("wr_ov", b_ov, mcnt != 0);
      if (po) begin
        chk("wr_data", b_od, recv);
        recv++;
      end
      if (pu) sent++;
      mcnt = mcnt + int'(pu) - int'(po);
      step();
      chk("wr_cnt", b_cnt, mcnt);
      chk("wr_cnt_le3", b_cnt <= 2'd3 && b_cnt != 2'd0 || b_cnt == 2'd0, 1);
      cyc++;
    end
    b_v = 1'b0;
    b_r = 1'b0;
    chk("wr_all_out", recv, 10);
    chk("wr_all_in", sent, 10);
    push_a(8'h61);
    push_a(8'h62);
    push_a(8'h63);
    chk("ar_pre_cnt", a_cnt, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_ov", a_ov, 0);
    chk("ar_ir", a_ir, 0);
    chk("ar_cnt", a_cnt, 0);
    step();
    reset = 1'b1;
    #1;
    chk("ar_rel_ir", a_ir, 1);
    chk("ar_rel_cnt", a_cnt, 0);
    push_a(8'h77);
    chk("ar_new_cnt", a_cnt, 1);
    chk("ar_new_od", a_od, 8'h77);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
